control: RTL

Sequencing controller for the expression-solver datapath (`operative`). On `start` it captures X and drives the mux selects, register loads and ALU opcode one step per clock. It evaluates either S = (A·X + B)·X + C (quadratic, Horner form) or S = A·X + B (linear). It then pulses `done` and reports a sticky overflow flag. It sits beside `operative` in the top level; all datapath control pins come from this block.

---
 rtl/control_pkg.sv | 48 ++++
 rtl/control_decode.sv | 65 ++++++
 rtl/control.sv | 98 +++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the expression-solver sequencer.
// State, mux-select, ALU-opcode and mode constants.
package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_MUL_AX = 3'd2,
    S_ADD_B  = 3'd3,
    S_MUL_HX = 3'd4,
    S_ADD_C  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  localparam logic [1:0] M1_SEL_M0 = 2'd0;
  localparam logic [1:0] M1_SEL_X  = 2'd1;
  localparam logic [1:0] M1_SEL_S  = 2'd2;
  localparam logic [1:0] M1_SEL_H  = 2'd3;

  localparam logic [1:0] M2_SEL_X  = 2'd0;
  localparam logic [1:0] M2_SEL_M0 = 2'd1;
  localparam logic [1:0] M2_SEL_S  = 2'd2;
  localparam logic [1:0] M2_SEL_H  = 2'd3;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  localparam logic MODE_QUAD = 1'b0;
  localparam logic MODE_LIN  = 1'b1;

  typedef struct packed {
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       busy;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational map from (state, latched mode) to datapath controls.
// Outputs depend on registered values only.
module control_decode
  import control_pkg::*;
(
  input  state_e state_i,
  input  logic   mode_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; ADD_B picks its target by mode.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_IDLE: begin
        ctrl_o = '0;
      end
      S_LOAD_X: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.lx   = 1'b1;
      end
      S_MUL_AX: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.m0   = SEL_A;
        ctrl_o.m1   = M1_SEL_M0;
        ctrl_o.m2   = M2_SEL_X;
        ctrl_o.h    = ALU_MUL;
        ctrl_o.lh   = 1'b1;
      end
      S_ADD_B: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.m0   = SEL_B;
        ctrl_o.m1   = M1_SEL_H;
        ctrl_o.m2   = M2_SEL_M0;
        ctrl_o.h    = ALU_ADD;
        ctrl_o.lh   = (mode_i == MODE_QUAD);
        ctrl_o.ls   = (mode_i == MODE_LIN);
      end
      S_MUL_HX: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.m0   = SEL_ZERO;
        ctrl_o.m1   = M1_SEL_H;
        ctrl_o.m2   = M2_SEL_X;
        ctrl_o.h    = ALU_MUL;
        ctrl_o.lh   = 1'b1;
      end
      S_ADD_C: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.m0   = SEL_C;
        ctrl_o.m1   = M1_SEL_H;
        ctrl_o.m2   = M2_SEL_M0;
        ctrl_o.h    = ALU_ADD;
        ctrl_o.ls   = 1'b1;
      end
      S_DONE: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.done = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/control.sv
// Sequencer for the expression-solver datapath.
// Holds state, latched mode and the sticky overflow flag.
module control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       overflow,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   ovf_q, ovf_d;
  ctrl_t  ctrl;

  // Next state, mode latch and overflow accumulation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        state_d = S_LOAD_X;
        mode_d  = mode;
        ovf_d   = 1'b0;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD_X: state_d = S_MUL_AX;
        S_MUL_AX: begin
          ovf_d   = ovf_q | overflow;
          state_d = S_ADD_B;
        end
        S_ADD_B: begin
          ovf_d   = ovf_q | overflow;
          state_d = (mode_q == MODE_LIN) ? S_DONE : S_MUL_HX;
        end
        S_MUL_HX: begin
          ovf_d   = ovf_q | overflow;
          state_d = S_ADD_C;
        end
        S_ADD_C: begin
          ovf_d   = ovf_q | overflow;
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, mode and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_QUAD;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  control_decode u_decode (
    .state_i (state_q),
    .mode_i  (mode_q),
    .ctrl_o  (ctrl)
  );

  assign LX   = ctrl.lx;
  assign LS   = ctrl.ls;
  assign LH   = ctrl.lh;
  assign H    = ctrl.h;
  assign M0   = ctrl.m0;
  assign M1   = ctrl.m1;
  assign M2   = ctrl.m2;
  assign busy = ctrl.busy;
  assign done = ctrl.done;
  assign ovf  = ovf_q;

endmodule
